// File: rtl/axi_sysid_reader.sv
// axi_sysid_reader
//
// Reads a sysid peripheral over an AXI4-Lite read channel.
// On each start pulse it runs this sequence:
//   1. Reads the magic word and checks it.
//   2. Captures the core version word.
//   3. Checks that the target's ROM address width matches ROM_ADDR_BITS.
//   4. Streams ROM_WORDS system-ROM words to a valid/ready consumer.
//
// Ports
//   m_axi_aclk, reset       clock, asynchronous active-high reset
//   start                   one-cycle pulse that begins a sequence
//   busy / done / error     sequence status (done/error held until next start)
//   err_code                1 magic, 2 rresp, 3 timeout, 4 ROM width mismatch
//   core_version            captured version word
//   rom_data/rom_index      ROM word and its index, qualified by rom_valid
//   rom_valid/rom_ready     consumer handshake
//   m_axi_ar*/m_axi_r*      AXI4-Lite read address / read data channels
module axi_sysid_reader #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          ROM_ADDR_BITS = 9,
  parameter int          ROM_WORDS     = 512,
  parameter int          TIMEOUT       = 1023
) (
  input  logic                     m_axi_aclk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [2:0]               err_code,
  output logic [31:0]              core_version,
  output logic [31:0]              rom_data,
  output logic                     rom_valid,
  input  logic                     rom_ready,
  output logic [ROM_ADDR_BITS-1:0] rom_index,
  output logic                     m_axi_arvalid,
  output logic [31:0]              m_axi_araddr,
  output logic [2:0]               m_axi_arprot,
  input  logic                     m_axi_arready,
  input  logic                     m_axi_rvalid,
  input  logic [1:0]               m_axi_rresp,
  input  logic [31:0]              m_axi_rdata,
  output logic                     m_axi_rready
);

  localparam logic [31:0] MAGIC         = 32'h5359_4944;
  localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT - 1);
  localparam logic [31:0] ROM_WORD_BASE = 32'd1 << ROM_ADDR_BITS;
  localparam logic [ROM_ADDR_BITS-1:0] LAST_IDX = ROM_ADDR_BITS'(ROM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, RD_MAGIC, RD_VERSION, RD_ABITS, RD_ROM, OUT, DONE, ERR
  } state_t;

  state_t                   state, state_nxt;
  // Within an RD_* state: 0 = address phase, 1 = data phase.
  logic                     data_ph, data_ph_nxt;
  logic [31:0]              cnt, cnt_nxt;
  logic [ROM_ADDR_BITS-1:0] idx, idx_nxt;
  logic                     clr, err_set, ver_ld, rom_ld;
  logic [2:0]               err_val;
  logic                     rd_state;

  // State and captured data registers
  always_ff @(posedge m_axi_aclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      data_ph      <= 1'b0;
      cnt          <= '0;
      idx          <= '0;
      err_code     <= '0;
      core_version <= '0;
      rom_data     <= '0;
      rom_index    <= '0;
    end else begin
      state   <= state_nxt;
      data_ph <= data_ph_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      if (clr)
        err_code <= '0;
      else if (err_set)
        err_code <= err_val;
      if (ver_ld)
        core_version <= m_axi_rdata;
      if (rom_ld) begin
        rom_data  <= m_axi_rdata;
        rom_index <= idx;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    data_ph_nxt = data_ph;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    clr         = 1'b0;
    err_set     = 1'b0;
    err_val     = 3'd0;
    ver_ld      = 1'b0;
    rom_ld      = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_nxt   = RD_MAGIC;
          data_ph_nxt = 1'b0;
          cnt_nxt     = '0;
          idx_nxt     = '0;
          clr         = 1'b1;
        end
      end
      RD_MAGIC, RD_VERSION, RD_ABITS, RD_ROM: begin
        // The handshake partner is arready in the address phase and
        // rvalid in the data phase; only the active one counts.
        if (data_ph ? m_axi_rvalid : m_axi_arready) begin
          cnt_nxt     = '0;
          data_ph_nxt = ~data_ph;
          if (data_ph) begin
            if (m_axi_rresp != 2'b00) begin
              state_nxt = ERR;
              err_set   = 1'b1;
              err_val   = 3'd2;
            end else begin
              case (state)
                RD_MAGIC: begin
                  if (m_axi_rdata != MAGIC) begin
                    state_nxt = ERR;
                    err_set   = 1'b1;
                    err_val   = 3'd1;
                  end else begin
                    state_nxt = RD_VERSION;
                  end
                end
                RD_VERSION: begin
                  ver_ld    = 1'b1;
                  state_nxt = RD_ABITS;
                end
                RD_ABITS: begin
                  if (m_axi_rdata != 32'(ROM_ADDR_BITS)) begin
                    state_nxt = ERR;
                    err_set   = 1'b1;
                    err_val   = 3'd4;
                  end else begin
                    state_nxt = RD_ROM;
                    idx_nxt   = '0;
                  end
                end
                RD_ROM: begin
                  rom_ld    = 1'b1;
                  state_nxt = OUT;
                end
                default: ;
              endcase
            end
          end
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = ERR;
          data_ph_nxt = 1'b0;
          err_set     = 1'b1;
          err_val     = 3'd3;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      OUT: begin
        if (rom_ready) begin
          data_ph_nxt = 1'b0;
          cnt_nxt     = '0;
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + ROM_ADDR_BITS'(1);
            state_nxt = RD_ROM;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    rd_state      = state inside {RD_MAGIC, RD_VERSION, RD_ABITS, RD_ROM};
    m_axi_arvalid = rd_state && !data_ph;
    m_axi_rready  = rd_state && data_ph;
    m_axi_arprot  = 3'b000;
    busy          = rd_state || (state == OUT);
    done          = (state == DONE);
    error         = (state == ERR);
    rom_valid     = (state == OUT);
    // The address is decoded from state and index, so it cannot change
    // while a request is waiting for arready.
    case (state)
      RD_MAGIC:   m_axi_araddr = BASE_ADDR + 32'h0000_000C;
      RD_VERSION: m_axi_araddr = BASE_ADDR;
      RD_ABITS:   m_axi_araddr = BASE_ADDR + 32'h0000_0040;
      RD_ROM:     m_axi_araddr = BASE_ADDR + ((ROM_WORD_BASE + 32'(idx)) << 2);
      default:    m_axi_araddr = '0;
    endcase
  end

endmodule
